block_transfer_seq: RTL

//  Multi-cycle load/store-multiple sequencer sitting directly upstream of the register file.

---
 rtl/block_transfer_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/block_transfer_seq.sv
// Load/store-multiple sequencer: walks a register list lowest index first, moving one
// word per cycle between data memory and the register file, then writes back the base.
module block_transfer_seq #(
  parameter int N = 4,
  parameter int M = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic [2**N-1:0]   reglist,
  input  logic [M-1:0]      base_addr,
  input  logic [N-1:0]      base_reg,
  input  logic              wb_en,
  output logic              busy,
  output logic              done,
  output logic [M-1:0]      mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [M-1:0]      mem_wd,
  input  logic [M-1:0]      mem_rd,
  output logic [N-1:0]      rf_a2,
  input  logic [M-1:0]      rf_rd2,
  output logic              rf_we3,
  output logic [N-1:0]      rf_a3,
  output logic [M-1:0]      rf_wd3,
  output logic              pc_wr
);

  localparam int L  = 2**N;
  localparam int CW = N + 1;
  localparam logic [M-1:0] STEP = M'(M / 8);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, DRAIN, WB, DONE} state_e;

  state_e         state_q, state_d;
  logic [L-1:0]   list_q, list_d;
  logic           load_q, load_d;
  logic           up_q, up_d;
  logic           wb_do_q, wb_do_d;
  logic [N-1:0]   base_reg_q, base_reg_d;
  logic [M-1:0]   base_q, base_d;      // holds the old base until SETUP, then new_base
  logic [M-1:0]   addr_q, addr_d;
  logic           ld_vld_q, ld_vld_d;
  logic [N-1:0]   ld_idx_q, ld_idx_d;

  logic [N-1:0]   idx;
  logic [CW-1:0]  cnt;
  logic [M-1:0]   span;

  always_comb begin
    idx = '0;
    for (int i = L - 1; i >= 0; i--) begin
      if (list_q[i]) idx = N'(i);
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < L; i++) cnt = cnt + CW'(list_q[i]);
  end

  assign span = M'(cnt) * STEP;

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      list_q     <= '0;
      load_q     <= 1'b0;
      up_q       <= 1'b0;
      wb_do_q    <= 1'b0;
      base_reg_q <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      ld_vld_q   <= 1'b0;
      ld_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      load_q     <= load_d;
      up_q       <= up_d;
      wb_do_q    <= wb_do_d;
      base_reg_q <= base_reg_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      ld_vld_q   <= ld_vld_d;
      ld_idx_q   <= ld_idx_d;
    end
  end

  // NOTE: every signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    load_d     = load_q;
    up_d       = up_q;
    wb_do_d    = wb_do_q;
    base_reg_d = base_reg_q;
    base_d     = base_q;
    addr_d     = addr_q;
    ld_vld_d   = 1'b0;
    ld_idx_d   = ld_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          list_d     = reglist;
          load_d     = is_load;
          up_d       = up;
          base_reg_d = base_reg;
          base_d     = base_addr;
          // A load into the base register wins over the written-back base.
          wb_do_d    = wb_en & ~(is_load & reglist[base_reg]);
          state_d    = (reglist == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        addr_d  = up_q ? base_q : base_q - span;
        base_d  = up_q ? base_q + span : base_q - span;
        state_d = XFER;
      end
      XFER: begin
        list_d   = list_q & (list_q - L'(1));
        addr_d   = addr_q + STEP;
        ld_vld_d = load_q;
        ld_idx_d = idx;
        if (list_d == '0) state_d = load_q ? DRAIN : WB;
      end
      DRAIN:   state_d = WB;
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    mem_addr = '0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    rf_a2    = '0;
    rf_we3   = 1'b0;
    rf_a3    = '0;
    rf_wd3   = '0;
    if (state_q == XFER) begin
      mem_addr = addr_q;
      if (load_q) begin
        mem_re = 1'b1;
      end else begin
        rf_a2  = idx;
        mem_we = 1'b1;
        mem_wd = rf_rd2;
      end
    end
    if (ld_vld_q) begin
      rf_we3 = 1'b1;
      rf_a3  = ld_idx_q;
      rf_wd3 = mem_rd;
    end
    if (state_q == WB && wb_do_q) begin
      rf_we3 = 1'b1;
      rf_a3  = base_reg_q;
      rf_wd3 = base_q;
    end
    pc_wr = rf_we3 && (rf_a3 == {N{1'b1}});
  end

endmodule
